// File: rtl/final2_soc_mem_pkg.sv
// Shared types and default sizes for the on-chip memory command master.
package final2_soc_mem_pkg;

    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_BE_W       = DEF_DATA_W / 8;
    localparam int DEF_FIFO_DEPTH = 4;

    // One queued host command. The field widths come from the package
    // defaults, so a top-level width override must be mirrored here.
    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_BE_W-1:0]   be;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_cmd_t;

    // IDLE issues commands; RD_WAIT covers the slave's read latency.
    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

endpackage

// File: rtl/final2_soc_cmd_fifo.sv
// Generic synchronous FIFO; dout shows the head entry whenever !empty.
module final2_soc_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = storage[rd_ptr[PTR_W-1:0]];

    // Entry storage write.
    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

    // Read/write pointer update.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/final2_soc_mem_cmd_master.sv
// Avalon-MM master: queues host read/write commands and plays them in order
// onto the on-chip memory slave, returning read data on a response stream.
module final2_soc_mem_cmd_master
    import final2_soc_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W/8-1:0] cmd_be,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    output logic              mem_reset_req,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int BE_W = DATA_W / 8;

    state_t   state;
    state_t   state_next;
    logic     rd_phase;
    logic     rd_phase_next;
    logic     rel_cnt;

    mem_cmd_t fifo_din;
    mem_cmd_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     push;
    logic     pop;

    logic     slot_free;
    logic     issue;
    logic     issue_write;
    logic     capture;

    // Host side: mem_clken doubles as the "out of reset" flag.
    assign cmd_ready = mem_clken && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign fifo_din  = '{write: cmd_write, addr: cmd_addr, be: cmd_be, wdata: cmd_wdata};

    // The response slot is free if empty now or being handed over this cycle.
    assign slot_free = !rsp_valid || rsp_ready;

    final2_soc_cmd_fifo #(
        .WIDTH ($bits(mem_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (fifo_din),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Hold the slave in reset for two clocks after reset_n rises, then enable it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rel_cnt       <= 1'b0;
            mem_reset_req <= 1'b1;
            mem_clken     <= 1'b0;
        end else if (mem_reset_req) begin
            rel_cnt <= 1'b1;
            if (rel_cnt) begin
                mem_reset_req <= 1'b0;
                mem_clken     <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_phase <= 1'b0;
        end else begin
            state    <= state_next;
            rd_phase <= rd_phase_next;
        end
    end

    // Issue decision and read-latency sequencing. RD_WAIT spans two cycles:
    // the cycle the read is on the bus, then the cycle the slave's q is valid.
    // NOTE: every output is defaulted first so no path can infer a latch.
    always_comb begin
        state_next    = state;
        rd_phase_next = rd_phase;
        pop           = 1'b0;
        issue         = 1'b0;
        issue_write   = 1'b0;
        capture       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head.write) begin
                        issue       = 1'b1;
                        issue_write = 1'b1;
                        pop         = 1'b1;
                    end else if (slot_free) begin
                        issue         = 1'b1;
                        pop           = 1'b1;
                        state_next    = RD_WAIT;
                        rd_phase_next = 1'b0;
                    end
                end
            end
            RD_WAIT: begin
                if (!rd_phase) begin
                    rd_phase_next = 1'b1;
                end else begin
                    capture       = 1'b1;
                    rd_phase_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered memory bus: strobes pulse for one clock per issued command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
        end else begin
            mem_chipselect <= issue;
            mem_write      <= issue_write;
            if (issue) begin
                mem_address    <= head.addr;
                mem_byteenable <= issue_write ? head.be : {BE_W{1'b1}};
                mem_writedata  <= head.wdata;
            end
        end
    end

    // Response holding register; a fresh capture wins over a same-cycle handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_readdata;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
